// File: rtl/div_exception_monitor.sv
// rtl/div_exception_monitor.sv - divide-by-zero exception monitor with queued reports
// Optional: define EXC_DISPLAY_EN for simulation messages on push/drop.
module div_exception_monitor #(
  parameter int                DATA_W      = 8,
  parameter int                PC_W        = 10,
  parameter int                INSTR_W     = 9,
  parameter logic [PC_W-1:0]   CHECK_PC_P1 = 10'd44,
  parameter logic [PC_W-1:0]   CHECK_PC_P2 = 10'd103,
  parameter int                QDEPTH      = 4,
  parameter int                CNT_W       = 4,
  parameter bit                HALT_ON_EXC = 1'b0
) (
  input  logic               CLK,
  input  logic               ResetN,
  input  logic [1:0]         ProgState,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic [DATA_W-1:0]  DataIn,
  input  logic [PC_W-1:0]    PC,
  input  logic               ExcAck,
  output logic               ExcValid,
  output logic [1:0]         ExcCode,
  output logic [PC_W-1:0]    ExcPC,
  output logic               Overrun,
  output logic [CNT_W-1:0]   ExcCount,
  output logic               Halt,
  output logic [DATA_W-1:0]  DivisorMsb,
  output logic [DATA_W-1:0]  DivisorLsb
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [INSTR_W-1:0] LW_R0 = INSTR_W'(9'b000_000_111);
  localparam logic [INSTR_W-1:0] LW_R1 = INSTR_W'(9'b000_001_111);
  localparam logic [INSTR_W-1:0] LW_R2 = INSTR_W'(9'b000_010_111);

  logic [1:0]      code_mem [QDEPTH];
  logic [PC_W-1:0] pc_mem   [QDEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic            match_q;

  logic m1, m2, match, ev1, ev2, exc_event, full, pop, do_push, drop;
  logic [1:0] ev_code;

  // Detection deliberately uses the registered divisor, so a same-cycle load is not seen.
  always_comb begin
    m1        = (ProgState == 2'b01) && (PC == CHECK_PC_P1);
    m2        = (ProgState == 2'b10) && (PC == CHECK_PC_P2);
    match     = m1 || m2;
    ev1       = m1 && !match_q && (DivisorMsb == '0) && (DivisorLsb == '0);
    ev2       = m2 && !match_q && (DivisorMsb == '0);
    exc_event = ev1 || ev2;
    ev_code   = ev2 ? 2'b10 : 2'b01;
    full      = (count == (AW+1)'(QDEPTH));
    pop       = ExcAck && ExcValid;
    do_push   = exc_event && (!full || pop);
    drop      = exc_event && full && !pop;
  end

  assign ExcValid = (count != '0);
  assign ExcCode  = code_mem[rptr];
  assign ExcPC    = pc_mem[rptr];
  assign Halt     = HALT_ON_EXC && ExcValid;

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      DivisorMsb <= '0;
      DivisorLsb <= '0;
    end else begin
      case (ProgState)
        2'b00: begin
          DivisorMsb <= '0;
          DivisorLsb <= '0;
        end
        2'b01: begin
          if (Instruction == LW_R0) DivisorMsb <= DataIn;
          if (Instruction == LW_R1) DivisorLsb <= DataIn;
        end
        2'b10: if (Instruction == LW_R2) DivisorMsb <= DataIn;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < QDEPTH; i++) begin
        code_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      match_q  <= 1'b0;
      Overrun  <= 1'b0;
      ExcCount <= '0;
    end else begin
      match_q <= match;
      if (do_push) begin
        code_mem[wptr] <= ev_code;
        pc_mem[wptr]   <= PC;
        wptr           <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (ProgState == 2'b00) Overrun <= 1'b0;
      else if (drop)          Overrun <= 1'b1;
      // Dropped events still count; the counter sticks at all-ones.
      if (exc_event && (ExcCount != '1)) ExcCount <= ExcCount + 1'b1;
    end
  end

`ifdef EXC_DISPLAY_EN
  always @(posedge CLK) begin
    if (ResetN) begin
      if (do_push) $display("Exception: Divisor is 0 (code %b, PC %0d)", ev_code, PC);
      if (drop)    $display("Exception queue overrun: dropped code %b, PC %0d", ev_code, PC);
    end
  end
`endif

endmodule

// File: tb/tb_div_exception_monitor.sv
// tb/tb_div_exception_monitor.sv - scoreboard bench for div_exception_monitor
module tb_div_exception_monitor;

  localparam logic [8:0] NOP   = 9'b000_000_000;
  localparam logic [8:0] LW_R0 = 9'b000_000_111;
  localparam logic [8:0] LW_R1 = 9'b000_001_111;
  localparam logic [8:0] LW_R2 = 9'b000_010_111;

  logic       CLK = 1'b0;
  logic       ResetN;
  logic [1:0] ProgState;
  logic [8:0] Instruction;
  logic [7:0] DataIn;
  logic [9:0] PC;
  logic       ExcAck;
  logic       ExcValid;
  logic [1:0] ExcCode;
  logic [9:0] ExcPC;
  logic       Overrun;
  logic [3:0] ExcCount;
  logic       Halt;
  logic [7:0] DivisorMsb, DivisorLsb;

  typedef struct packed {logic [1:0] code; logic [9:0] pc;} exc_t;
  exc_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  logic exp_ovr  = 1'b0;

  always #5 CLK = ~CLK;

  div_exception_monitor #(.HALT_ON_EXC(1'b1)) dut (
    .CLK(CLK), .ResetN(ResetN), .ProgState(ProgState), .Instruction(Instruction),
    .DataIn(DataIn), .PC(PC), .ExcAck(ExcAck), .ExcValid(ExcValid), .ExcCode(ExcCode),
    .ExcPC(ExcPC), .Overrun(Overrun), .ExcCount(ExcCount), .Halt(Halt),
    .DivisorMsb(DivisorMsb), .DivisorLsb(DivisorLsb)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic [1:0] ps, input logic [8:0] ins, input logic [7:0] d,
                       input logic [9:0] pc);
    ProgState = ps; Instruction = ins; DataIn = d; PC = pc;
    @(posedge CLK); #1;
  endtask

  // One checkpoint cycle followed by a non-matching cycle; model records the expected outcome.
  task automatic fire(input logic [1:0] ps, input logic [9:0] pc);
    if (sb.size() < 4) sb.push_back({ps, pc});
    else exp_ovr = 1'b1;
    if (exp_cnt < 15) exp_cnt++;
    cycle(ps, NOP, 8'h00, pc);
    cycle(ps, NOP, 8'h00, 10'd0);
  endtask

  task automatic pop_check(input string tag);
    exc_t e;
    check_eq({tag, "_valid"}, ExcValid, 1);
    check_eq({tag, "_halt"}, Halt, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({tag, "_code"}, ExcCode, e.code);
      check_eq({tag, "_pc"}, ExcPC, e.pc);
    end
    ExcAck = 1'b1;
    cycle(ProgState, NOP, 8'h00, 10'd0);
    ExcAck = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, ExcValid, 0);
    check_eq({tag, "_halt"}, Halt, 0);
    check_eq({tag, "_code"}, ExcCode, 0);
    check_eq({tag, "_pc"}, ExcPC, 0);
    check_eq({tag, "_ovr"}, Overrun, 0);
    check_eq({tag, "_cnt"}, ExcCount, 0);
    check_eq({tag, "_msb"}, DivisorMsb, 0);
    check_eq({tag, "_lsb"}, DivisorLsb, 0);
  endtask

  initial begin
    exc_t e;
    ResetN = 1'b0; ExcAck = 1'b0;
    ProgState = 2'b00; Instruction = NOP; DataIn = 8'h00; PC = 10'd0;
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset");
    ResetN = 1'b1;

    // Prog1 with zero divisor
    cycle(2'b01, LW_R0, 8'h00, 10'd10);
    cycle(2'b01, LW_R1, 8'h00, 10'd11);
    fire(2'b01, 10'd44);
    check_eq("p1_cnt", ExcCount, exp_cnt);
    pop_check("p1");
    check_eq("p1_empty", ExcValid, 0);

    // Empty ack is ignored
    ExcAck = 1'b1;
    cycle(2'b01, NOP, 8'h00, 10'd0);
    ExcAck = 1'b0;
    check_eq("eack_valid", ExcValid, 0);
    check_eq("eack_cnt", ExcCount, exp_cnt);

    // Nonzero divisor, stalled at checkpoint
    cycle(2'b01, LW_R1, 8'h03, 10'd12);
    check_eq("ld_lsb", DivisorLsb, 8'h03);
    repeat (3) cycle(2'b01, NOP, 8'h00, 10'd44);
    check_eq("nz_valid", ExcValid, 0);
    check_eq("nz_cnt", ExcCount, exp_cnt);
    cycle(2'b01, LW_R1, 8'h00, 10'd12);
    sb.push_back({2'b01, 10'd44});
    exp_cnt++;
    repeat (3) cycle(2'b01, NOP, 8'h00, 10'd44);
    cycle(2'b01, NOP, 8'h00, 10'd0);
    check_eq("stall_cnt", ExcCount, exp_cnt);
    pop_check("stall");
    check_eq("stall_empty", ExcValid, 0);

    // Prog2: same-cycle load must not hide the zero divisor
    sb.push_back({2'b10, 10'd103});
    exp_cnt++;
    cycle(2'b10, LW_R2, 8'h05, 10'd103);
    check_eq("p2_msb", DivisorMsb, 8'h05);
    cycle(2'b10, NOP, 8'h00, 10'd50);
    cycle(2'b10, NOP, 8'h00, 10'd103);
    cycle(2'b10, NOP, 8'h00, 10'd50);
    check_eq("p2_cnt", ExcCount, exp_cnt);
    pop_check("p2");
    check_eq("p2_empty", ExcValid, 0);

    // Fresh start for overflow test
    ResetN = 1'b0;
    cycle(2'b00, NOP, 8'h00, 10'd0);
    ResetN = 1'b1;
    sb.delete(); exp_cnt = 0; exp_ovr = 1'b0;
    fire(2'b01, 10'd44);
    fire(2'b10, 10'd103);
    fire(2'b01, 10'd44);
    fire(2'b10, 10'd103);
    check_eq("full_ovr0", Overrun, exp_ovr);
    fire(2'b01, 10'd44);
    check_eq("full_ovr1", Overrun, exp_ovr);
    check_eq("full_cnt", ExcCount, exp_cnt);
    for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
    check_eq("drain_empty", ExcValid, 0);

    // ProgState 00 clears divisors and Overrun, keeps count
    cycle(2'b01, LW_R0, 8'h07, 10'd5);
    check_eq("ld_msb", DivisorMsb, 8'h07);
    cycle(2'b00, NOP, 8'h00, 10'd0);
    check_eq("idle_msb", DivisorMsb, 0);
    check_eq("idle_lsb", DivisorLsb, 0);
    check_eq("idle_ovr", Overrun, 0);
    check_eq("idle_cnt", ExcCount, exp_cnt);
    exp_ovr = 1'b0;

    // Full queue with simultaneous push and pop
    fire(2'b01, 10'd44);
    fire(2'b10, 10'd103);
    fire(2'b01, 10'd44);
    fire(2'b10, 10'd103);
    e = sb.pop_front();
    check_eq("pp_code", ExcCode, e.code);
    check_eq("pp_pc", ExcPC, e.pc);
    sb.push_back({2'b01, 10'd44});
    exp_cnt++;
    ExcAck = 1'b1;
    cycle(2'b01, NOP, 8'h00, 10'd44);
    ExcAck = 1'b0;
    cycle(2'b01, NOP, 8'h00, 10'd0);
    check_eq("pp_ovr", Overrun, exp_ovr);
    check_eq("pp_cnt", ExcCount, exp_cnt);
    for (int i = 0; i < 4; i++) pop_check($sformatf("ppdrain%0d", i));
    check_eq("pp_empty", ExcValid, 0);

    // Async reset with a pending entry
    fire(2'b01, 10'd44);
    check_eq("ar_valid", ExcValid, 1);
    #2 ResetN = 1'b0;
    #1;
    check_zero("async_rst");
    sb.delete(); exp_cnt = 0;
    @(posedge CLK); #1;
    ResetN = 1'b1;
    cycle(2'b00, NOP, 8'h00, 10'd0);
    check_eq("post_rst_valid", ExcValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
